// File: rtl/battle_pkg.sv
// Shared types and encodings for the battleship turn controller.
package battle_pkg;

    localparam int DEFAULT_N = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SHOT,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_SWITCH,
        S_GAME_OVER
    } state_t;

    localparam logic [1:0] CELL_UNSHOT = 2'd0;
    localparam logic [1:0] CELL_MISS   = 2'd1;
    localparam logic [1:0] CELL_HIT    = 2'd2;

    // Hit counters stick at their maximum instead of wrapping.
    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Idle-cycle counter for the shooting window; expire marks the last allowed cycle.
module turn_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expire
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt;

    // Holds at LAST so a deferred expiry is still seen on the next idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count_en && (cnt != LAST)) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expire = count_en && (cnt == LAST);

endmodule

// File: rtl/battle_turn_ctrl.sv
// Two-player battleship turn sequencer: accepts shots, checks and updates the
// board registers, keeps score and forfeits turns on inactivity.
module battle_turn_ctrl
    import battle_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int SHIP_CELLS = 5,
    parameter int TIMEOUT    = 1023
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           shot_valid,
    input  logic [2:0]     shot_row,
    input  logic [2:0]     shot_col,
    output logic           shot_ready,
    input  logic [N*N-1:0] ship_map_p0,
    input  logic [N*N-1:0] ship_map_p1,
    output logic           cell_player,
    output logic [2:0]     cell_row,
    output logic [2:0]     cell_col,
    input  logic [1:0]     cell_rd_state,
    output logic           cell_we,
    output logic [1:0]     cell_wr_state,
    output logic           clr_boards,
    output logic           turn,
    output logic           shot_hit,
    output logic           shot_miss,
    output logic           shot_bad,
    output logic           turn_skipped,
    output logic           game_over,
    output logic           winner,
    output logic [4:0]     hits_p0,
    output logic [4:0]     hits_p1
);

    localparam logic [3:0] N4    = 4'(N);
    localparam logic [4:0] SHIP5 = 5'(SHIP_CELLS);

    state_t         state, state_nx;
    logic           accept, in_range, accept_ok, accept_bad;
    logic           start_game, expire, skip, timer_load;
    logic           opp_bit, win, cell_taken;
    logic [N*N-1:0] opp_map, opp_sh;
    logic [4:0]     shooter_hits;

    assign accept     = shot_valid && (state == S_WAIT_SHOT);
    assign in_range   = ({1'b0, shot_row} < N4) && ({1'b0, shot_col} < N4);
    assign accept_ok  = accept && in_range;
    assign accept_bad = accept && !in_range;
    assign start_game = start && ((state == S_IDLE) || (state == S_GAME_OVER));
    // Any accepted shot in the expiry cycle takes precedence over the forfeit.
    assign skip       = expire && !accept;
    assign cell_taken = (cell_rd_state != CELL_UNSHOT);

    // The addressed board belongs to the opponent, so its ship map decides hit/miss.
    assign opp_map      = cell_player ? ship_map_p1 : ship_map_p0;
    assign opp_sh       = opp_map >> (int'(cell_row) * N + int'(cell_col));
    assign opp_bit      = opp_sh[0];
    assign shooter_hits = turn ? hits_p1 : hits_p0;
    assign win          = (shooter_hits == SHIP5);

    turn_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .count_en (state == S_WAIT_SHOT),
        .expire   (expire)
    );

    always_comb begin
        state_nx   = state;
        timer_load = 1'b0;
        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    state_nx   = S_WAIT_SHOT;
                    timer_load = 1'b1;
                end
            end
            S_WAIT_SHOT: begin
                if (accept_ok) begin
                    state_nx   = S_READ;
                    timer_load = 1'b1;
                end else if (skip) begin
                    timer_load = 1'b1;
                end
            end
            S_READ:  state_nx = S_CHECK;
            S_CHECK: begin
                if (cell_taken) begin
                    state_nx   = S_WAIT_SHOT;
                    timer_load = 1'b1;
                end else begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: state_nx = S_SWITCH;
            S_SWITCH: begin
                if (win) begin
                    state_nx = S_GAME_OVER;
                end else begin
                    state_nx   = S_WAIT_SHOT;
                    timer_load = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign shot_ready    = (state == S_WAIT_SHOT);
    assign cell_we       = (state == S_WRITE);
    assign cell_wr_state = cell_we ? (opp_bit ? CELL_HIT : CELL_MISS) : CELL_UNSHOT;
    assign shot_hit      = cell_we && opp_bit;
    assign shot_miss     = cell_we && !opp_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            turn         <= 1'b0;
            hits_p0      <= '0;
            hits_p1      <= '0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
            cell_player  <= 1'b0;
            cell_row     <= '0;
            cell_col     <= '0;
            shot_bad     <= 1'b0;
            turn_skipped <= 1'b0;
            clr_boards   <= 1'b0;
        end else begin
            state        <= state_nx;
            shot_bad     <= accept_bad || ((state == S_CHECK) && cell_taken);
            turn_skipped <= skip;
            clr_boards   <= start_game;

            if (start_game) begin
                hits_p0   <= '0;
                hits_p1   <= '0;
                turn      <= 1'b0;
                game_over <= 1'b0;
                winner    <= 1'b0;
            end

            if (accept_ok) begin
                cell_row    <= shot_row;
                cell_col    <= shot_col;
                cell_player <= ~turn;
            end

            if (skip) begin
                turn <= ~turn;
            end

            if (cell_we && opp_bit) begin
                if (turn) hits_p1 <= sat_inc5(hits_p1);
                else      hits_p0 <= sat_inc5(hits_p0);
            end

            if (state == S_SWITCH) begin
                if (win) begin
                    game_over <= 1'b1;
                    winner    <= turn;
                end else begin
                    turn <= ~turn;
                end
            end
        end
    end

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Scoreboard bench for battle_turn_ctrl with a behavioural board-register model.
module tb_battle_turn_ctrl;

    localparam int N  = 5;
    localparam int NN = N * N;

    typedef struct {
        logic [2:0] kind;   // one-hot {bad, hit, miss}
        logic       player;
        logic [2:0] row;
        logic [2:0] col;
        logic [1:0] wr;
        bit         win;
        int         lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          shot_valid = 1'b0;
    logic [2:0]    shot_row = '0;
    logic [2:0]    shot_col = '0;
    logic          shot_ready;
    logic [NN-1:0] ship_map_p0;
    logic [NN-1:0] ship_map_p1;
    logic          cell_player;
    logic [2:0]    cell_row, cell_col;
    logic [1:0]    cell_rd_state = '0;
    logic          cell_we;
    logic [1:0]    cell_wr_state;
    logic          clr_boards, turn, shot_hit, shot_miss, shot_bad, turn_skipped;
    logic          game_over, winner;
    logic [4:0]    hits_p0, hits_p1;

    int   n_chk = 0;
    int   n_err = 0;
    int   we_cnt = 0;
    int   exp_we = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic [1:0] env_board [2][NN];
    logic [1:0] mdl_board [2][NN];
    logic       exp_turn;
    int         exp_hits [2];

    battle_turn_ctrl #(.N(N), .SHIP_CELLS(5), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .shot_valid(shot_valid), .shot_row(shot_row), .shot_col(shot_col),
        .shot_ready(shot_ready),
        .ship_map_p0(ship_map_p0), .ship_map_p1(ship_map_p1),
        .cell_player(cell_player), .cell_row(cell_row), .cell_col(cell_col),
        .cell_rd_state(cell_rd_state), .cell_we(cell_we), .cell_wr_state(cell_wr_state),
        .clr_boards(clr_boards), .turn(turn),
        .shot_hit(shot_hit), .shot_miss(shot_miss), .shot_bad(shot_bad),
        .turn_skipped(turn_skipped), .game_over(game_over), .winner(winner),
        .hits_p0(hits_p0), .hits_p1(hits_p1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Board register: read data valid one cycle after the address, cleared by clr_boards.
    always @(posedge clk) begin
        int idx;
        idx = int'(cell_row) * N + int'(cell_col);
        if (clr_boards) begin
            for (int p = 0; p < 2; p++)
                for (int i = 0; i < NN; i++) env_board[p][i] <= 2'd0;
        end else if (cell_we && idx < NN) begin
            env_board[cell_player][idx] <= cell_wr_state;
        end
        cell_rd_state <= (idx < NN) ? env_board[cell_player][idx] : 2'd0;
    end

    // Result monitor: every result pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (cell_we) we_cnt++;
        if (!reset && (shot_hit || shot_miss || shot_bad)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("result", 32'({shot_bad, shot_hit, shot_miss}), 32'(mon_e.kind));
                if (mon_e.kind[2]) begin
                    chk("bad_no_we", 32'(cell_we), 32'd0);
                end else begin
                    chk("we", 32'(cell_we), 32'd1);
                    chk("wr_player", 32'(cell_player), 32'(mon_e.player));
                    chk("wr_addr", 32'({cell_row, cell_col}), 32'({mon_e.row, mon_e.col}));
                    chk("wr_state", 32'(cell_wr_state), 32'(mon_e.wr));
                end
            end
        end
    end

    task automatic predict(input logic [2:0] r, input logic [2:0] c, output exp_t e);
        int  idx;
        bit  hit;
        e.player = ~exp_turn;
        e.row = r;
        e.col = c;
        e.wr = 2'd0;
        e.win = 1'b0;
        if (int'(r) >= N || int'(c) >= N) begin
            e.kind = 3'b100;
            e.lat = 1;
        end else begin
            idx = int'(r) * N + int'(c);
            if (mdl_board[e.player][idx] != 2'd0) begin
                e.kind = 3'b100;
                e.lat = 3;
            end else begin
                hit = e.player ? ship_map_p1[idx] : ship_map_p0[idx];
                e.kind = hit ? 3'b010 : 3'b001;
                e.wr = hit ? 2'd2 : 2'd1;
                e.lat = 5;
                mdl_board[e.player][idx] = e.wr;
                exp_we++;
                if (hit && exp_hits[exp_turn] < 31) exp_hits[exp_turn]++;
                if (exp_hits[exp_turn] == 5) e.win = 1'b1;
                else exp_turn = ~exp_turn;
            end
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NN; i++) mdl_board[p][i] = 2'd0;
        exp_hits[0] = 0;
        exp_hits[1] = 0;
        exp_turn = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where the outcome is settled.
    task automatic fire(input logic [2:0] r, input logic [2:0] c);
        exp_t e;
        int   n;
        n = 0;
        while (!shot_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(shot_ready), 32'd1);
        predict(r, c, e);
        sb.push_back(e);
        shot_row = r;
        shot_col = c;
        shot_valid = 1'b1;
        @(posedge clk);
        #1 shot_valid = 1'b0;
        if (e.win) begin
            repeat (5) @(negedge clk);
            chk("game_over", 32'(game_over), 32'd1);
            chk("winner", 32'(winner), 32'(exp_turn));
            chk("ready_after_win", 32'(shot_ready), 32'd0);
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!shot_ready && n < 12);
            chk("latency", 32'(n), 32'(e.lat));
        end
        chk("turn", 32'(turn), 32'(exp_turn));
        chk("hits_p0", 32'(hits_p0), 32'(exp_hits[0]));
        chk("hits_p1", 32'(hits_p1), 32'(exp_hits[1]));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        ship_map_p0 = '0;
        ship_map_p1 = '0;
        for (int i = 0; i < 5; i++) ship_map_p0[i] = 1'b1;   // row 0 of P0's board
        ship_map_p1[7] = 1'b1;
        ship_map_p1[12] = 1'b1;
        ship_map_p1[13] = 1'b1;
        ship_map_p1[20] = 1'b1;
        ship_map_p1[24] = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NN; i++) env_board[p][i] = 2'd3;
        clear_model();

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(shot_ready), 32'd0);
        chk("rst_turn", 32'(turn), 32'd0);
        chk("rst_go", 32'({game_over, winner}), 32'd0);
        chk("rst_hits", 32'({hits_p0, hits_p1}), 32'd0);
        chk("rst_we", 32'({cell_we, clr_boards}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(shot_ready), 32'd0);

        // Start clears boards and opens the first turn
        pulse_start();
        chk("start_clr", 32'(clr_boards), 32'd1);
        chk("start_ready", 32'(shot_ready), 32'd1);
        @(negedge clk);
        chk("clr_one_cycle", 32'(clr_boards), 32'd0);

        fire(3'd1, 3'd2);   // P0 hit
        fire(3'd3, 3'd3);   // P1 miss

        // start during play is ignored
        pulse_start();
        chk("start_ignored", 32'(clr_boards), 32'd0);
        chk("start_ign_turn", 32'(turn), 32'(exp_turn));

        fire(3'd5, 3'd0);   // P0 out of range
        fire(3'd0, 3'd7);   // P0 out of range (col)
        fire(3'd0, 3'd0);   // P0 miss
        fire(3'd0, 3'd0);   // P1 hit
        fire(3'd1, 3'd2);   // P0 repeat on a HIT cell
        fire(3'd0, 3'd0);   // P0 repeat on a MISS cell

        // Idle timeout forfeits P0's turn
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!turn_skipped && n < 20);
        chk("skip_cycles", 32'(n), 32'd8);
        exp_turn = ~exp_turn;
        chk("skip_turn", 32'(turn), 32'(exp_turn));
        @(negedge clk);
        chk("skip_pulse", 32'(turn_skipped), 32'd0);

        fire(3'd0, 3'd1);   // P1 hit 2
        fire(3'd3, 3'd0);
        fire(3'd0, 3'd2);   // P1 hit 3
        fire(3'd3, 3'd1);
        fire(3'd0, 3'd3);   // P1 hit 4
        fire(3'd3, 3'd2);
        fire(3'd0, 3'd4);   // P1 hit 5, wins

        // Shots in GAME_OVER are ignored
        shot_row = 3'd1;
        shot_col = 3'd1;
        shot_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("go_ready", 32'(shot_ready), 32'd0);
        shot_valid = 1'b0;
        @(negedge clk);
        chk("go_hold", 32'(game_over), 32'd1);

        // Restart from GAME_OVER
        pulse_start();
        clear_model();
        chk("restart_clr", 32'(clr_boards), 32'd1);
        chk("restart_hits", 32'({hits_p0, hits_p1}), 32'd0);
        chk("restart_go", 32'({game_over, winner}), 32'd0);
        chk("restart_turn", 32'(turn), 32'd0);

        fire(3'd1, 3'd2);   // P0 hit on freshly cleared board

        // Reset during the WRITE cycle of P1's shot at (0,1)
        begin
            exp_t e;
            predict(3'd0, 3'd1, e);
            sb.push_back(e);
            shot_row = 3'd0;
            shot_col = 3'd1;
            shot_valid = 1'b1;
            @(posedge clk);
            #1 shot_valid = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            chk("write_we", 32'(cell_we), 32'd1);
            reset = 1'b1;
            #1;
            chk("rstw_we", 32'({cell_we, shot_hit, shot_miss}), 32'd0);
            chk("rstw_ready", 32'(shot_ready), 32'd0);
            chk("rstw_turn", 32'(turn), 32'd0);
            chk("rstw_hits", 32'({hits_p0, hits_p1}), 32'd0);
            chk("rstw_addr", 32'({cell_player, cell_row, cell_col}), 32'd0);
            chk("rstw_go", 32'({game_over, winner, clr_boards, shot_bad, turn_skipped}), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(shot_ready), 32'd0);
        chk("post_rst_we", 32'(cell_we), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("we_count", 32'(we_cnt), 32'(exp_we));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
